// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives the combinational instruction
// memory and buffers fetched words in a small circular prefetch queue feeding decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                imem_address,
    input  logic [31:0]                imem_instruction,
    input  logic                       fetch_enable,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instruction,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc_plus_8,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [31:0]   fetchPcQ, fetchPcD;
    logic [PW-1:0] rdPtrQ, rdPtrD;
    logic [PW-1:0] wrPtrQ, wrPtrD;
    logic [CW-1:0] countQ, countD;
    logic [31:0]   pcMem    [DEPTH];
    logic [31:0]   instrMem [DEPTH];
    logic          notEmpty;
    logic          push;
    logic          pop;

    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign imem_address = fetchPcQ;
    assign notEmpty     = (countQ != '0);
    assign out_valid    = notEmpty & ~redirect_valid;
    assign pop          = out_valid & out_ready;
    assign push         = fetch_enable & ~redirect_valid & ((countQ < FULL) | pop);
    assign queue_count  = countQ;

    assign out_instruction = notEmpty ? instrMem[rdPtrQ]          : '0;
    assign out_pc          = notEmpty ? pcMem[rdPtrQ]             : '0;
    assign out_pc_plus_8   = notEmpty ? pcMem[rdPtrQ] + 32'd8     : '0;

    always_comb begin
        fetchPcD = fetchPcQ;
        rdPtrD   = rdPtrQ;
        wrPtrD   = wrPtrQ;
        countD   = countQ;
        if (redirect_valid) begin
            fetchPcD = {redirect_target[31:2], 2'b00};
            rdPtrD   = '0;
            wrPtrD   = '0;
            countD   = '0;
        end else begin
            if (push) begin
                fetchPcD = fetchPcQ + 32'd4;
                wrPtrD   = nextPtr(wrPtrQ);
            end
            if (pop) begin
                rdPtrD = nextPtr(rdPtrQ);
            end
            case ({push, pop})
                2'b10:   countD = countQ + CW'(1);
                2'b01:   countD = countQ - CW'(1);
                default: countD = countQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPcQ <= RESET_VECTOR;
            rdPtrQ   <= '0;
            wrPtrQ   <= '0;
            countQ   <= '0;
        end else begin
            fetchPcQ <= fetchPcD;
            rdPtrQ   <= rdPtrD;
            wrPtrQ   <= wrPtrD;
            countQ   <= countD;
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtrQ]    <= fetchPcQ;
            instrMem[wrPtrQ] <= imem_instruction;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a FIFO-level model of expected deliveries is
// filled by the stimulus process and drained by an independent monitor at each negedge.
module tb_instr_fetch_unit;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 2;
    localparam int          CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   imem_address;
    logic [31:0]   imem_instruction;
    logic          fetch_enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_target = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instruction;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc_plus_8;
    logic [CW-1:0] queue_count;

    int            checks = 0;
    int            passes = 0;
    int            popCount = 0;
    logic [63:0]   sbq[$];
    logic [31:0]   modelPc = RV;

    instr_fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .fetch_enable    (fetch_enable),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_pc_plus_8   (out_pc_plus_8),
        .queue_count     (queue_count)
    );

    always #5 clk = ~clk;

    // Deterministic memory contents so every address returns a distinct word.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    assign imem_instruction = memWord(imem_address);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drives one cycle of inputs, then advances the model by what that edge must do.
    task automatic applyStimulus(input logic en, input logic rdy, input logic rv, input logic [31:0] tgt);
        fetch_enable    = en;
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(posedge clk);
        #1;
        if (rv) begin
            sbq.delete();
            modelPc = {tgt[31:2], 2'b00};
        end else if (en && sbq.size() < DEPTH) begin
            sbq.push_back({modelPc, memWord(modelPc)});
            modelPc = modelPc + 32'd4;
        end
    endtask

    task automatic resetPulse();
        #2;
        reset = 1'b1;
        sbq.delete();
        modelPc = RV;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_addr", imem_address, RV);
        checkOutput("async_rst_count", queue_count, 0);
        #3;
        reset = 1'b0;
    endtask

    // Monitor: pops the expected head whenever a handshake is due this cycle.
    initial begin
        logic expValid;
        logic [63:0] head;
        forever begin
            @(negedge clk);
            expValid = (sbq.size() != 0) && !redirect_valid;
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("queue_count", queue_count, sbq.size());
            checkOutput("imem_address", imem_address, modelPc);
            if (sbq.size() == 0) begin
                checkOutput("empty_instr", out_instruction, 0);
                checkOutput("empty_pc", out_pc, 0);
                checkOutput("empty_pc8", out_pc_plus_8, 0);
            end else if (expValid) begin
                head = sbq[0];
                checkOutput("out_instruction", out_instruction, head[31:0]);
                checkOutput("out_pc", out_pc, head[63:32]);
                checkOutput("out_pc_plus_8", out_pc_plus_8, head[63:32] + 32'd8);
                if (out_ready) begin
                    void'(sbq.pop_front());
                    popCount++;
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        #12;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, '0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0);
        applyStimulus(1, 1, 1, 32'h0000_0043);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 1, 1, 32'h0000_1000);
        applyStimulus(1, 1, 1, 32'h0000_2002);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0);
        resetPulse();
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0);

        for (int i = 0; i < 2000; i++) begin
            tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            applyStimulus($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 8, tgt);
            if ($urandom_range(0, 99) == 0) resetPulse();
        end
        applyStimulus(1, 1, 0, '0);

        checkOutput("items_delivered", popCount > 100, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch initiator that drives the combinational instruction memory.
- Holds the fetch PC and presents it as the word address to the instruction memory.
- Captures the returned instruction word into a small prefetch queue.
- Delivers {instruction, pc, pc+8} to the decode stage over a valid/ready handshake.
- Handles branch redirects (queue flush plus PC reload) and a fetch-enable gate. Sits between the PC/branch logic and the instruction memory at the front of the pipeline.

Parameters:
RESET_VECTOR, 32'h0000_0000, fetch PC value after reset; bits [1:0] must be 0.
DEPTH, 2, prefetch queue entries; legal range 1..8.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
imem_address  output  32  byte address to instruction memory; equals fetch_pc.
imem_instruction  input  32  instruction word returned combinationally for imem_address.
fetch_enable  input  1  1 = fetch permitted; 0 = no new pushes (queue still drains).
redirect_valid  input  1  branch taken this cycle.
redirect_target  input  32  new fetch byte address.
out_valid  output  1  queue head valid to decode.
out_ready  input  1  decode accepts head.
out_instruction  output  32  head instruction word.
out_pc  output  32  byte address of head instruction.
out_pc_plus_8  output  32  out_pc + 8 (ARM PC-read value), modulo 2^32.
queue_count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc = RESET_VECTOR; queue emptied; queue_count = 0; out_valid = 0.
  - out_instruction, out_pc, out_pc_plus_8 = 0.
  - imem_address = RESET_VECTOR.
- Reset asserted mid-operation discards all queue contents and any in-flight redirect. No state survives.
- imem_address = fetch_pc, driven combinationally from the register. Memory read is zero-latency: imem_instruction is sampled at the same clock edge.
- pop = out_valid & out_ready.
- push = fetch_enable & ~redirect_valid & (queue_count < DEPTH | pop).
  - On push: enqueue {fetch_pc, imem_instruction}; fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Simultaneous push and pop when full is legal. Occupancy is unchanged and order is preserved (FIFO).
- out_valid = (queue_count != 0) & ~redirect_valid. The head is gated off during a redirect cycle, so no pop occurs then.
- Head outputs are zero when the queue is empty.
- Redirect (redirect_valid = 1 at edge):
  - Queue flushed; queue_count = 0.
  - fetch_pc <= {redirect_target[31:2], 2'b00}: target is word-aligned, low bits are silently dropped.
  - Redirect overrides push and pop in that cycle.
- Latency:
  - Reset released before edge E0: first instruction is pushed at E0, and out_valid = 1 after E0.
  - Redirect at edge R: imem_address = target after R; target instruction is pushed at R+1, and out_valid = 1 after R+1.
  - Redirect-to-valid penalty is 2 cycles.
- Back-to-back redirects: each one restarts the sequence. Only the last target is fetched.
- fetch_enable = 0: fetch_pc holds and no push occurs. The queue keeps draining through the handshake. When fetch_enable returns to 1, fetch resumes at the held fetch_pc.
- out_ready with out_valid = 0 has no effect.
- Queue implementation: circular buffer with read/write pointers and a count. Pointers wrap at DEPTH, including non-power-of-2 values.

Test Plan:
- Reset/stream: RESET_VECTOR=0; memory words 0..4 preloaded; out_ready=1. Required: one cycle after release, out_pc=0 with out_pc_plus_8=8; then pc=4, 8, 12, 16 on consecutive cycles; imem_address leads out_pc by 4.
- Backpressure: out_ready=0 for 5 cycles. Required: queue_count saturates at 2, fetch_pc holds at 8, out_pc stays 0. Releasing out_ready delivers pc 0, 4, 8 in order with no loss or duplication.
- Redirect: redirect_valid with target 32'h0000_0043 while queue is full. Required: next cycle out_valid=0, queue_count=0, imem_address=32'h40; the cycle after, out_pc=32'h40.
- Wrap: redirect to 32'hFFFF_FFFC. Required: out_pc=32'hFFFF_FFFC with out_pc_plus_8=32'h0000_0004, then out_pc=0.
- Fetch gate: fetch_enable=0 with 2 queued entries and out_ready=1. Required: both entries drain, out_valid falls, imem_address is constant. Raising fetch_enable resumes at the held address.
- Async reset mid-stream: reset pulse between clock edges. Required: out_valid=0 and imem_address=RESET_VECTOR immediately, before the next clock edge.
